// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: reset vector, NOP encoding, fetch FSM states.
package mips_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP    = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load / hold / bubble control.
// A bubble takes precedence over a load; the pc fields hold across a bubble.
module if_id_reg
  import mips_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        bubble_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic        misaligned_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        misaligned_o
);

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        mis_q, mis_d;

  // Next-state selection: hold by default, bubble clears the payload, load captures.
  always_comb begin
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    mis_d      = mis_q;
    if (bubble_i) begin
      valid_d = 1'b0;
      instr_d = INSTR_NOP;
      mis_d   = 1'b0;
    end else if (load_i) begin
      valid_d    = 1'b1;
      instr_d    = instr_i;
      pc_d       = pc_i;
      pc_plus4_d = pc_i + 32'd4;
      mis_d      = misaligned_i;
    end
  end

  // Register update with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q    <= 1'b0;
      instr_q    <= INSTR_NOP;
      pc_q       <= 32'd0;
      pc_plus4_q <= 32'd0;
      mis_q      <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      mis_q      <= mis_d;
    end
  end

  assign valid_o      = valid_q;
  assign instr_o      = instr_q;
  assign pc_o         = pc_q;
  assign pc_plus4_o   = pc_plus4_q;
  assign misaligned_o = mis_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, BOOT/RUN/HALT control, fetch counter and IF/ID register.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_VECTOR
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        id_misaligned,
  output logic        halted,
  output logic [31:0] fetch_count
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         mis_q, mis_d;
  logic         halted_q, halted_d;
  logic [31:0]  count_q, count_d;
  logic         load, bubble;

  // Redirect targets are word-aligned; the dropped low bits are remembered in mis_q.
  logic [31:0] redirect_target;
  assign redirect_target = {redirect_pc[31:2], 2'b00};

  // Next-state: priority redirect > halt > flush > stall > normal fetch while running.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mis_d   = mis_q;
    count_d = count_q;
    load    = 1'b0;
    bubble  = 1'b0;
    unique case (state_q)
      BOOT: begin
        bubble  = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        if (redirect_valid) begin
          bubble = 1'b1;
          pc_d   = redirect_target;
          mis_d  = |redirect_pc[1:0];
        end else if (halt) begin
          bubble  = 1'b1;
          state_d = HALT;
        end else if (flush) begin
          bubble = 1'b1;
        end else if (!stall) begin
          load    = 1'b1;
          pc_d    = pc_q + 32'd4;
          mis_d   = 1'b0;
          count_d = count_q + 32'd1;
        end
      end
      HALT: begin
        bubble = 1'b1;
        if (redirect_valid) begin
          pc_d    = redirect_target;
          mis_d   = |redirect_pc[1:0];
          state_d = RUN;
        end
      end
      default: begin
        bubble  = 1'b1;
        state_d = BOOT;
      end
    endcase
    halted_d = (state_d == HALT);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= BOOT;
      pc_q     <= {RESET_PC[31:2], 2'b00};
      mis_q    <= 1'b0;
      halted_q <= 1'b0;
      count_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      mis_q    <= mis_d;
      halted_q <= halted_d;
      count_q  <= count_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .load_i       (load),
    .bubble_i     (bubble),
    .instr_i      (imem_data),
    .pc_i         (pc_q),
    .misaligned_i (mis_q),
    .valid_o      (id_valid),
    .instr_o      (id_instr),
    .pc_o         (id_pc),
    .pc_plus4_o   (id_pc_plus4),
    .misaligned_o (id_misaligned)
  );

  assign imem_addr   = pc_q;
  assign halted      = halted_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit; instruction memory returns 32'h2001_0001 + word index.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall, flush, redirect_valid, halt;
  logic [31:0] redirect_pc;
  logic        id_valid, id_misaligned, halted;
  logic [31:0] id_instr, id_pc, id_pc_plus4, fetch_count;

  int checks;
  int failures;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4),
    .id_misaligned  (id_misaligned),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational instruction memory: word k holds 32'h2001_0001 + k.
  assign imem_data = 32'h2001_0001 + {2'b00, imem_addr[31:2]};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; halt = 1'b0; redirect_pc = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    tick(); tick();
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%h exp=0", id_valid); end
    checks++; if (id_instr !== 32'h0) begin failures++; $display("FAIL rst_instr got=%h exp=0", id_instr); end
    checks++; if (id_pc !== 32'h0 || id_pc_plus4 !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h/%h exp=0/0", id_pc, id_pc_plus4); end
    checks++; if (fetch_count !== 32'h0 || halted !== 1'b0 || id_misaligned !== 1'b0) begin failures++; $display("FAIL rst_misc got cnt=%h halted=%b mis=%b exp=0", fetch_count, halted, id_misaligned); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
  endtask

  task automatic test_boot_and_stream();
    rst_n = 1'b1;
    tick();
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL boot_valid got=%h exp=0", id_valid); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL boot_addr got=%h exp=0", imem_addr); end
    tick();
    checks++; if (id_valid !== 1'b1 || id_instr !== 32'h2001_0001 || id_pc !== 32'h0 || id_pc_plus4 !== 32'h4 || fetch_count !== 32'd1) begin failures++; $display("FAIL fetch0 got v=%b i=%h pc=%h p4=%h c=%0d exp v=1 i=20010001 pc=0 p4=4 c=1", id_valid, id_instr, id_pc, id_pc_plus4, fetch_count); end
    tick();
    checks++; if (id_valid !== 1'b1 || id_instr !== 32'h2001_0002 || id_pc !== 32'h4 || fetch_count !== 32'd2) begin failures++; $display("FAIL fetch1 got v=%b i=%h pc=%h c=%0d exp v=1 i=20010002 pc=4 c=2", id_valid, id_instr, id_pc, fetch_count); end
    tick();
    checks++; if (id_valid !== 1'b1 || id_instr !== 32'h2001_0003 || id_pc !== 32'h8 || fetch_count !== 32'd3 || imem_addr !== 32'hC) begin failures++; $display("FAIL fetch2 got v=%b i=%h pc=%h c=%0d a=%h exp v=1 i=20010003 pc=8 c=3 a=c", id_valid, id_instr, id_pc, fetch_count, imem_addr); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (id_valid !== 1'b1 || id_instr !== 32'h2001_0003 || id_pc !== 32'h8 || imem_addr !== 32'hC || fetch_count !== 32'd3) begin failures++; $display("FAIL stall_hold%0d got v=%b i=%h pc=%h a=%h c=%0d exp v=1 i=20010003 pc=8 a=c c=3", i, id_valid, id_instr, id_pc, imem_addr, fetch_count); end
    end
    stall = 1'b0;
    tick();
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'hC || id_instr !== 32'h2001_0004 || fetch_count !== 32'd4) begin failures++; $display("FAIL stall_release got v=%b pc=%h i=%h c=%0d exp v=1 pc=c i=20010004 c=4", id_valid, id_pc, id_instr, fetch_count); end
  endtask

  task automatic test_redirect_priority();
    // Redirect wins over stall, flush and halt in the same cycle.
    stall = 1'b1; flush = 1'b1; halt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    clear_inputs();
    checks++; if (imem_addr !== 32'h40 || id_valid !== 1'b0 || id_instr !== 32'h0 || id_pc !== 32'hC) begin failures++; $display("FAIL redir_n1 got a=%h v=%b i=%h pc=%h exp a=40 v=0 i=0 pc=c", imem_addr, id_valid, id_instr, id_pc); end
    checks++; if (halted !== 1'b0 || fetch_count !== 32'd4) begin failures++; $display("FAIL redir_prio got halted=%b c=%0d exp halted=0 c=4", halted, fetch_count); end
    tick();
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h40 || id_pc_plus4 !== 32'h44 || id_instr !== 32'h2001_0011 || id_misaligned !== 1'b0 || fetch_count !== 32'd5) begin failures++; $display("FAIL redir_n2 got v=%b pc=%h p4=%h i=%h m=%b c=%0d exp v=1 pc=40 p4=44 i=20010011 m=0 c=5", id_valid, id_pc, id_pc_plus4, id_instr, id_misaligned, fetch_count); end
  endtask

  task automatic test_misaligned();
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    tick();
    clear_inputs();
    checks++; if (imem_addr !== 32'h40 || id_valid !== 1'b0) begin failures++; $display("FAIL mis_addr got a=%h v=%b exp a=40 v=0", imem_addr, id_valid); end
    tick();
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h40 || id_misaligned !== 1'b1 || fetch_count !== 32'd6) begin failures++; $display("FAIL mis_first got v=%b pc=%h m=%b c=%0d exp v=1 pc=40 m=1 c=6", id_valid, id_pc, id_misaligned, fetch_count); end
    tick();
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h44 || id_misaligned !== 1'b0 || id_instr !== 32'h2001_0012 || fetch_count !== 32'd7) begin failures++; $display("FAIL mis_next got v=%b pc=%h m=%b i=%h c=%0d exp v=1 pc=44 m=0 i=20010012 c=7", id_valid, id_pc, id_misaligned, id_instr, fetch_count); end
  endtask

  task automatic test_halt();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    checks++; if (halted !== 1'b1 || id_valid !== 1'b0 || imem_addr !== 32'h48 || fetch_count !== 32'd7) begin failures++; $display("FAIL halt_enter got h=%b v=%b a=%h c=%0d exp h=1 v=0 a=48 c=7", halted, id_valid, imem_addr, fetch_count); end
    for (int i = 0; i < 5; i++) begin
      flush = i[0]; stall = ~i[0]; halt = (i == 2);
      tick();
      checks++; if (halted !== 1'b1 || id_valid !== 1'b0 || imem_addr !== 32'h48 || fetch_count !== 32'd7) begin failures++; $display("FAIL halt_idle%0d got h=%b v=%b a=%h c=%0d exp h=1 v=0 a=48 c=7", i, halted, id_valid, imem_addr, fetch_count); end
    end
    clear_inputs();
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    tick();
    clear_inputs();
    checks++; if (halted !== 1'b0 || id_valid !== 1'b0 || imem_addr !== 32'h10) begin failures++; $display("FAIL halt_exit got h=%b v=%b a=%h exp h=0 v=0 a=10", halted, id_valid, imem_addr); end
    tick();
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h10 || id_instr !== 32'h2001_0005 || fetch_count !== 32'd8) begin failures++; $display("FAIL halt_resume got v=%b pc=%h i=%h c=%0d exp v=1 pc=10 i=20010005 c=8", id_valid, id_pc, id_instr, fetch_count); end
  endtask

  task automatic test_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (id_valid !== 1'b0 || id_instr !== 32'h0 || id_pc !== 32'h10 || id_pc_plus4 !== 32'h14 || imem_addr !== 32'h14 || fetch_count !== 32'd8) begin failures++; $display("FAIL flush_bubble got v=%b i=%h pc=%h p4=%h a=%h c=%0d exp v=0 i=0 pc=10 p4=14 a=14 c=8", id_valid, id_instr, id_pc, id_pc_plus4, imem_addr, fetch_count); end
    tick();
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h14 || id_instr !== 32'h2001_0006 || fetch_count !== 32'd9) begin failures++; $display("FAIL flush_refetch got v=%b pc=%h i=%h c=%0d exp v=1 pc=14 i=20010006 c=9", id_valid, id_pc, id_instr, fetch_count); end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    clear_inputs();
    tick();
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'hFFFF_FFFC || id_pc_plus4 !== 32'h0 || id_instr !== 32'h6001_0000 || imem_addr !== 32'h0 || fetch_count !== 32'd10) begin failures++; $display("FAIL wrap_top got v=%b pc=%h p4=%h i=%h a=%h c=%0d exp v=1 pc=fffffffc p4=0 i=60010000 a=0 c=10", id_valid, id_pc, id_pc_plus4, id_instr, imem_addr, fetch_count); end
    tick();
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_pc_plus4 !== 32'h4 || id_instr !== 32'h2001_0001 || fetch_count !== 32'd11) begin failures++; $display("FAIL wrap_next got v=%b pc=%h p4=%h i=%h c=%0d exp v=1 pc=0 p4=4 i=20010001 c=11", id_valid, id_pc, id_pc_plus4, id_instr, fetch_count); end
  endtask

  task automatic test_mid_reset();
    rst_n = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h80; halt = 1'b1;
    tick();
    clear_inputs();
    checks++; if (id_valid !== 1'b0 || id_instr !== 32'h0 || id_pc !== 32'h0 || id_pc_plus4 !== 32'h0 || id_misaligned !== 1'b0 || halted !== 1'b0 || fetch_count !== 32'h0 || imem_addr !== 32'h0) begin failures++; $display("FAIL midrst_clear got v=%b i=%h pc=%h p4=%h m=%b h=%b c=%0d a=%h exp all 0", id_valid, id_instr, id_pc, id_pc_plus4, id_misaligned, halted, fetch_count, imem_addr); end
    rst_n = 1'b1;
    tick();
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL midrst_boot got v=%b exp 0", id_valid); end
    tick();
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== 32'h2001_0001 || fetch_count !== 32'd1) begin failures++; $display("FAIL midrst_first got v=%b pc=%h i=%h c=%0d exp v=1 pc=0 i=20010001 c=1", id_valid, id_pc, id_instr, fetch_count); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_boot_and_stream();
    test_stall();
    test_redirect_priority();
    test_misaligned();
    test_halt();
    test_flush();
    test_wrap();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
